// File: rtl/gpu_prefetch_pkg.sv
// Shared constants and types for the GPU instruction prefetch queue.
// Latency: n/a (constants, types and a pointer helper only).
// Backpressure: n/a.
package gpu_prefetch_pkg;

  // Halfword address width (byte address bits 23..1).
  localparam int ADDR_W = 23;
  // Queue capacity in halfwords; even and no more than 6 so the count fits in 3 bits.
  localparam int DEPTH  = 4;
  // Width of the buffer index actually used to address storage.
  localparam int IDX_W  = $clog2(DEPTH);

  // Fetch FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_STALE = 2'd2;

  // Occupancy count and buffer pointers.
  typedef logic [2:0] qcnt_t;

  // Advance a circular-buffer pointer, wrapping modulo DEPTH.
  function automatic qcnt_t ptr_inc(input qcnt_t p);
    return (p == qcnt_t'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/pfq_pc_sub.sv
// Head-instruction PC: halfword fetch address minus queue occupancy.
// Latency: purely combinational; wraps modulo 2^ADDR_W.
// Backpressure: none.
// Ports: base (fetch address with skip folded into bit 0), count (halfwords held),
//        diff (address of the head instruction).
module pfq_pc_sub
  import gpu_prefetch_pkg::*;
(
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        count,
  output logic [ADDR_W-1:0] diff
);

  assign diff = base - {{(ADDR_W-3){1'b0}}, count};

endmodule

// File: rtl/gpu_prefetch_queue.sv
// Instruction prefetch queue: fetches 32-bit longwords, buffers 16-bit halfwords, presents head + PC.
// Latency: flush to mem_req 1 cycle; mem_ack to instr_valid 1 cycle; pc/instr combinational from state.
// Backpressure: a longword is only requested when room exists for both halfwords, so no overflow.
// Ports: sys_clk/resetl clock and async active-low reset; flush/jump_addr restart fetch;
//        mem_req/mem_addr/mem_ack/mem_data longword fetch handshake (data valid with ack);
//        instr/instr_valid/instr_pop decoder side; pc head address; qcount occupancy.
// Optional: GPU_PREFETCH_STATS_EN adds stall_count (pops seen while empty, saturating).
module gpu_prefetch_queue
  import gpu_prefetch_pkg::*;
(
  input  logic              sys_clk,
  input  logic              resetl,
  input  logic              flush,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_pop,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        qcount
`ifdef GPU_PREFETCH_STATS_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  logic [15:0]       buf_q [DEPTH];
  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_addr;
  logic              skip;
  qcnt_t             rd_ptr;
  qcnt_t             wr_ptr;

  logic              ack_take;
  logic              pop_take;
  qcnt_t             add_cnt;
  qcnt_t             q_next;
  logic [ADDR_W-1:0] next_fetch;
  logic [ADDR_W-1:0] flush_tgt;
  qcnt_t             wr_ptr_p1;

  // Acks only deliver data in REQ; in STALE the data belongs to an abandoned stream.
  assign ack_take   = (state == ST_REQ) && mem_ack && !flush;
  assign pop_take   = instr_pop && (qcount != 3'd0) && !flush;
  assign add_cnt    = ack_take ? (skip ? 3'd1 : 3'd2) : 3'd0;
  assign q_next     = qcount + add_cnt - {2'b00, pop_take};
  assign next_fetch = fetch_addr + {{(ADDR_W-2){1'b0}}, 2'd2};
  assign flush_tgt  = {jump_addr[ADDR_W-1:1], 1'b0};
  assign wr_ptr_p1  = ptr_inc(wr_ptr);

  assign instr       = buf_q[rd_ptr[IDX_W-1:0]];
  assign instr_valid = (qcount != 3'd0);

  // An odd target is fetched from the even longword; skip folds the +1 back into the PC.
  pfq_pc_sub u_pc_sub (
    .base  ({fetch_addr[ADDR_W-1:1], fetch_addr[0] | skip}),
    .count (qcount),
    .diff  (pc)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_addr <= '0;
      skip       <= 1'b0;
      qcount     <= 3'd0;
      rd_ptr     <= 3'd0;
      wr_ptr     <= 3'd0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (flush) begin
      qcount     <= 3'd0;
      rd_ptr     <= 3'd0;
      wr_ptr     <= 3'd0;
      fetch_addr <= flush_tgt;
      skip       <= jump_addr[0];
      case (state)
        ST_REQ: begin
          // The bus request cannot be withdrawn; reissue at the target only once it completes.
          if (mem_ack) mem_addr <= flush_tgt;
          else         state    <= ST_STALE;
        end
        ST_STALE: begin
          if (mem_ack) begin
            state    <= ST_REQ;
            mem_addr <= flush_tgt;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end else begin
      qcount <= q_next;
      if (pop_take) rd_ptr <= ptr_inc(rd_ptr);
      case (state)
        ST_IDLE: begin
          if (qcount <= qcnt_t'(DEPTH - 2)) begin
            state    <= ST_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        end
        ST_REQ: begin
          if (ack_take) begin
            // High halfword sits at the lower address, so it enters the queue first.
            if (skip) begin
              buf_q[wr_ptr[IDX_W-1:0]] <= mem_data[15:0];
              wr_ptr                   <= wr_ptr_p1;
            end else begin
              buf_q[wr_ptr[IDX_W-1:0]]    <= mem_data[31:16];
              buf_q[wr_ptr_p1[IDX_W-1:0]] <= mem_data[15:0];
              wr_ptr                      <= ptr_inc(wr_ptr_p1);
            end
            skip       <= 1'b0;
            fetch_addr <= next_fetch;
            if (q_next <= qcnt_t'(DEPTH - 2)) begin
              mem_addr <= next_fetch;
            end else begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        ST_STALE: begin
          if (mem_ack) begin
            state    <= ST_REQ;
            mem_addr <= fetch_addr;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef GPU_PREFETCH_STATS_EN
  // Counts decoder pops that found the queue empty; saturates rather than wrapping.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      stall_count <= 16'h0000;
    end else if (flush) begin
      stall_count <= 16'h0000;
    end else if (instr_pop && (qcount == 3'd0) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_prefetch_queue.sv
// Directed bench for gpu_prefetch_queue with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Stall-counter checks are built only when GPU_PREFETCH_STATS_EN is defined.
module tb_gpu_prefetch_queue;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        flush;
  logic [22:0] jump_addr;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_pop;
  logic [22:0] pc;
  logic [2:0]  qcount;
`ifdef GPU_PREFETCH_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  gpu_prefetch_queue dut (
    .sys_clk     (sys_clk),
    .resetl      (resetl),
    .flush       (flush),
    .jump_addr   (jump_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pop   (instr_pop),
    .pc          (pc),
    .qcount      (qcount)
`ifdef GPU_PREFETCH_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    resetl    = 1'b0;
    flush     = 1'b0;
    jump_addr = '0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    instr_pop = 1'b0;
    repeat (3) tick;

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_qcount", 32'(qcount), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);

    // Leave reset with a flush to 0x100 so the first fetch goes there
    resetl    = 1'b1;
    flush     = 1'b1;
    jump_addr = 23'h000100;
    tick;
    flush = 1'b0;
    chk("flush_q0", 32'(qcount), 32'h0);
    tick;
    chk("t1_req", 32'(mem_req), 32'h1);
    chk("t1_addr0", 32'(mem_addr), 32'h100);

    mem_ack  = 1'b1;
    mem_data = 32'h11112222;
    tick;
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_instr0", 32'(instr), 32'h1111);
    chk("t1_q2", 32'(qcount), 32'h2);
    chk("t1_pc0", 32'(pc), 32'h100);
    chk("t1_addr1", 32'(mem_addr), 32'h102);

    mem_data = 32'h33334444;
    tick;
    mem_ack = 1'b0;
    chk("fill_q4", 32'(qcount), 32'h4);
    chk("fill_req0", 32'(mem_req), 32'h0);
    tick;
    chk("fill_req0_hold", 32'(mem_req), 32'h0);

    // Pops walk the head and PC; request only returns once two slots are free
    instr_pop = 1'b1;
    chk("pop_instr0", 32'(instr), 32'h1111);
    chk("pop_pc0", 32'(pc), 32'h100);
    tick;
    chk("pop_q3", 32'(qcount), 32'h3);
    chk("pop_instr1", 32'(instr), 32'h2222);
    chk("pop_pc1", 32'(pc), 32'h101);
    chk("pop_q3_noreq", 32'(mem_req), 32'h0);
    tick;
    instr_pop = 1'b0;
    chk("pop_q2", 32'(qcount), 32'h2);
    chk("pop_instr2", 32'(instr), 32'h3333);
    chk("pop_pc2", 32'(pc), 32'h102);
    chk("pop_q2_noreq_yet", 32'(mem_req), 32'h0);
    tick;
    chk("refill_req", 32'(mem_req), 32'h1);
    chk("refill_addr", 32'(mem_addr), 32'h104);

    // Pop and ack together with qcount=2
    mem_ack   = 1'b1;
    mem_data  = 32'h55556666;
    instr_pop = 1'b1;
    chk("popack_old_head", 32'(instr), 32'h3333);
    tick;
    mem_ack   = 1'b0;
    instr_pop = 1'b0;
    chk("popack_q3", 32'(qcount), 32'h3);
    chk("popack_instr", 32'(instr), 32'h4444);
    chk("popack_pc", 32'(pc), 32'h103);
    chk("popack_req0", 32'(mem_req), 32'h0);

    // Odd jump target
    flush     = 1'b1;
    jump_addr = 23'h000205;
    tick;
    flush = 1'b0;
    chk("odd_q0", 32'(qcount), 32'h0);
    chk("odd_valid0", 32'(instr_valid), 32'h0);
    chk("odd_pc_empty", 32'(pc), 32'h205);
    tick;
    chk("odd_req", 32'(mem_req), 32'h1);
    chk("odd_addr", 32'(mem_addr), 32'h204);
    mem_ack  = 1'b1;
    mem_data = 32'hAAAABBBB;
    tick;
    mem_ack = 1'b0;
    chk("odd_q1", 32'(qcount), 32'h1);
    chk("odd_instr", 32'(instr), 32'hBBBB);
    chk("odd_pc", 32'(pc), 32'h205);
    chk("odd_next_addr", 32'(mem_addr), 32'h206);

    // Flush while the 0x206 request is outstanding
    flush     = 1'b1;
    jump_addr = 23'h000300;
    tick;
    flush = 1'b0;
    chk("stale_req_held", 32'(mem_req), 32'h1);
    chk("stale_addr_held", 32'(mem_addr), 32'h206);
    chk("stale_q0", 32'(qcount), 32'h0);
    tick;
    tick;
    chk("stale_req_held2", 32'(mem_req), 32'h1);
    chk("stale_addr_held2", 32'(mem_addr), 32'h206);
    mem_ack  = 1'b1;
    mem_data = 32'hDEADBEEF;
    tick;
    mem_ack = 1'b0;
    chk("stale_discard_q", 32'(qcount), 32'h0);
    chk("stale_discard_valid", 32'(instr_valid), 32'h0);
    chk("stale_new_req", 32'(mem_req), 32'h1);
    chk("stale_new_addr", 32'(mem_addr), 32'h300);
    mem_ack  = 1'b1;
    mem_data = 32'h77778888;
    tick;
    mem_ack = 1'b0;
    chk("after_stale_instr", 32'(instr), 32'h7777);
    chk("after_stale_pc", 32'(pc), 32'h300);
    chk("after_stale_q2", 32'(qcount), 32'h2);

    // Drain two, then three pops while empty
    instr_pop = 1'b1;
    tick;
    chk("drain_instr", 32'(instr), 32'h8888);
    repeat (4) tick;
    instr_pop = 1'b0;
    chk("empty_pop_q0", 32'(qcount), 32'h0);
`ifdef GPU_PREFETCH_STATS_EN
    chk("stall_count3", 32'(stall_count), 32'h3);
`endif
    flush     = 1'b1;
    jump_addr = 23'h000500;
    tick;
    flush = 1'b0;
`ifdef GPU_PREFETCH_STATS_EN
    chk("stall_flush_clr", 32'(stall_count), 32'h0);
`endif
    chk("flush500_req_held", 32'(mem_req), 32'h1);
    mem_ack  = 1'b1;
    mem_data = 32'h0;
    tick;
    mem_data = 32'h12345678;
    tick;
    mem_ack = 1'b0;
    chk("pre_rst_q2", 32'(qcount), 32'h2);
    chk("pre_rst_pc", 32'(pc), 32'h500);
    chk("pre_rst_req", 32'(mem_req), 32'h1);

    // Asynchronous reset in the middle of a clock period
    #2;
    resetl = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'h0);
    chk("arst_q", 32'(qcount), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_valid", 32'(instr_valid), 32'h0);
    tick;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/gpu_prefetch_queue.md
Name: gpu_prefetch_queue

Overview:
- Instruction prefetch queue for the TOM GPU.
- Fetches 32-bit big-endian longwords from local memory and buffers them as 16-bit instruction halfwords.
- Presents the head instruction to the decoder.
- Computes the architectural PC of the head instruction as fetch address minus queue occupancy; this feeds the PC/jump logic downstream.

Parameters:
- ADDR_W, 23: halfword address width (byte address bits 23..1).
- DEPTH, 4: queue capacity in halfwords. Must be even and ≤6, so that the count fits in 3 bits.

Ports:
- sys_clk, in, 1: system clock.
- resetl, in, 1: asynchronous active-low reset.
- flush, in, 1: jump/branch taken; restart fetch at jump_addr.
- jump_addr, in, ADDR_W: halfword target address.
- mem_req, out, 1: longword fetch request.
- mem_addr, out, ADDR_W: halfword address of the request; bit 0 is always 0.
- mem_ack, in, 1: request accepted; mem_data is valid in the same cycle.
- mem_data, in, 32: fetched longword. Bits 31:16 are the lower halfword address.
- instr, out, 16: head instruction.
- instr_valid, out, 1: queue not empty.
- instr_pop, in, 1: decoder consumes the head.
- pc, out, ADDR_W: halfword address of the head instruction.
- qcount, out, 3: halfwords held.

Behaviour:
- Reset (async, resetl=0) sets all of the following:
  - mem_req=0, mem_addr=0, fetch_addr=0.
  - qcount=0, instr_valid=0, instr=0, pc=0.
  - skip=0, state=IDLE.
- Storage:
  - DEPTH×16 circular buffer with 3-bit read/write pointers that wrap modulo DEPTH.
  - instr is driven combinationally from the read pointer.
- FSM states: IDLE, REQ, STALE.
  - IDLE → REQ when qcount ≤ DEPTH−2 and flush=0. mem_req=1 and mem_addr=fetch_addr are registered in the same edge.
  - REQ: mem_req/mem_addr stay stable until mem_ack. On ack:
    - Write the high halfword, then the low halfword; qcount += 2.
    - fetch_addr += 2.
    - If qcount after the update is ≤ DEPTH−2, stay in REQ (back-to-back) and present the new address next cycle; else go to IDLE with mem_req=0.
  - REQ with flush=1 and no ack → STALE. The request cannot be abandoned, so mem_req is held.
  - STALE: on mem_ack, discard the data and go to REQ at the new fetch_addr.
  - REQ with flush and mem_ack in the same cycle: the data is discarded; the next state is REQ at the new address.
- Skip (odd jump target):
  - When skip=1, the first accepted longword writes only its low halfword; qcount += 1; then skip clears.
- Flush (highest priority):
  - Clears qcount and both pointers.
  - fetch_addr = {jump_addr[ADDR_W−1:1],0}; skip = jump_addr[0].
  - Any pop or ack in the same cycle is ignored for queue purposes.
- Pop:
  - When qcount>0, advance the read pointer; qcount −= 1.
  - Pop while empty is ignored.
  - Pop and ack in the same cycle: qcount += 1 (or += 0 when skipping); the pop reads the old head.
- Space check: a request is only issued when room exists for the whole longword, so overflow is impossible.
- PC arithmetic: pc = (fetch_addr | skip) − qcount, zero-extended, modulo 2^ADDR_W. Wrap at address 0 is permitted.
- Latency:
  - Flush to mem_req is 1 cycle.
  - mem_ack to instr_valid is 1 cycle.

Optional Feature:
- Macro: GPU_PREFETCH_STATS_EN.
- When defined:
  - Adds output stall_count[15:0]: cycles with instr_pop=1 and qcount=0.
  - The counter saturates at 16'hFFFF.
  - It is cleared by reset and by flush.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package gpu_prefetch_pkg holds:
  - ADDR_W.
  - DEPTH.
  - State encoding (IDLE=0, REQ=1, STALE=2).
  - The 3-bit count type.
- Sub-module pfq_pc_sub: combinational ADDR_W-bit minus 3-bit subtractor producing pc. It is instantiated once.

Test Plan:
- Reset, then flush with jump_addr=0x000100; memory acks every cycle with 0x11112222, 0x33334444.
  - Expect mem_addr 0x000100 then 0x000102.
  - Expect instr 0x1111, 0x2222, 0x3333 in order.
  - Expect pc 0x100, 0x101, 0x102 on successive pops.
- Odd jump_addr=0x000205, data 0xAAAABBBB.
  - Expect mem_addr=0x000204.
  - Expect qcount=1, instr=0xBBBB, pc=0x205.
- Fill to qcount=4 with no pops.
  - Expect mem_req=0 and no further request.
  - One pop gives qcount=3, still no request; a second pop gives qcount=2, and mem_req rises next cycle.
- Flush while REQ is outstanding (ack delayed 3 cycles, stale data 0xDEADBEEF).
  - Expect mem_req held, then data discarded.
  - Next request at the new target; 0xDEAD is never seen on instr.
- Simultaneous pop and ack with qcount=2.
  - Expect qcount=3 and the popped value to be the old head.
- Pop with qcount=0 three times (stats macro on).
  - Expect qcount stays 0 and stall_count=3.
  - A subsequent flush clears stall_count to 0.
- Assert resetl=0 mid-REQ.
  - Expect mem_req=0, qcount=0 and pc=0 immediately, without waiting for a clock edge.
